// File: rtl/reset_sequencer.sv
// reset_sequencer: releases per-domain resets in order once PLL lock has been stable.
// Define RESET_SEQ_LOSS_COUNT_EN to build the saturating lock-loss event counter.
module reset_sequencer #(
   parameter int NUM_DOMAINS        = 3,
   parameter int LOCK_STABLE_CYCLES = 16,
   parameter int STAGE_DELAY        = 8,
   parameter int MIN_ASSERT         = 4
) (
   input  logic                   clk_in,
   input  logic                   reset_in,
   input  logic                   pll_locked_in,
   input  logic                   sw_reset_req,
   output logic [NUM_DOMAINS-1:0] reset_out,
   output logic                   ready_out,
   output logic [7:0]             loss_count_out
);
   localparam int MAX_LS = (LOCK_STABLE_CYCLES > STAGE_DELAY) ? LOCK_STABLE_CYCLES : STAGE_DELAY;
   localparam int MAX_P  = (MAX_LS > MIN_ASSERT) ? MAX_LS : MIN_ASSERT;
   localparam int CW     = $clog2(MAX_P) + 1;

   localparam logic [CW-1:0] ASSERT_LAST = CW'(MIN_ASSERT - 1);
   localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CW-1:0] STAGE_LAST  = CW'(STAGE_DELAY - 1);

   localparam logic [2:0] ST_ASSERT    = 3'd0;
   localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
   localparam logic [2:0] ST_STABLE    = 3'd2;
   localparam logic [2:0] ST_RELEASE   = 3'd3;
   localparam logic [2:0] ST_RUN       = 3'd4;

   logic [2:0]             state, state_nx;
   logic [CW-1:0]          cnt, cnt_nx;
   logic [NUM_DOMAINS-1:0] rst_nx;
   logic                   ready_nx;
   logic                   lock_meta, lock_sync;
   logic                   lock_lost;

   assign lock_lost = ((state == ST_RELEASE) || (state == ST_RUN)) && !lock_sync;

   // sw_reset_req is a single-cycle pulse with no acknowledge; it is acted on the edge it is seen.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt + CW'(1);
      rst_nx   = reset_out;
      ready_nx = ready_out;
      if (sw_reset_req || lock_lost) begin
         state_nx = ST_ASSERT;
         cnt_nx   = '0;
         rst_nx   = '1;
         ready_nx = 1'b0;
      end else begin
         case (state)
            ST_ASSERT: begin
               if (cnt == ASSERT_LAST) begin
                  state_nx = ST_WAIT_LOCK;
                  cnt_nx   = '0;
               end
            end
            ST_WAIT_LOCK: begin
               cnt_nx = '0;
               if (lock_sync) state_nx = ST_STABLE;
            end
            ST_STABLE: begin
               if (!lock_sync) begin
                  state_nx = ST_WAIT_LOCK;
                  cnt_nx   = '0;
               end else if (cnt == STABLE_LAST) begin
                  state_nx = ST_RELEASE;
                  cnt_nx   = '0;
               end
            end
            ST_RELEASE: begin
               // Counter restarts per stage; the lowest still-asserted bit is the next to release.
               if (cnt == STAGE_LAST) begin
                  cnt_nx = '0;
                  rst_nx = reset_out & (reset_out - NUM_DOMAINS'(1));
                  if (rst_nx == '0) begin
                     state_nx = ST_RUN;
                     ready_nx = 1'b1;
                  end
               end
            end
            ST_RUN: begin
               cnt_nx = '0;
            end
            default: begin
               state_nx = ST_ASSERT;
               cnt_nx   = '0;
               rst_nx   = '1;
               ready_nx = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_in) begin
      if (!reset_in) begin
         state     <= ST_ASSERT;
         cnt       <= '0;
         lock_meta <= 1'b0;
         lock_sync <= 1'b0;
         reset_out <= '1;
         ready_out <= 1'b0;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         lock_meta <= pll_locked_in;
         lock_sync <= lock_meta;
         reset_out <= rst_nx;
         ready_out <= ready_nx;
      end
   end

`ifdef RESET_SEQ_LOSS_COUNT_EN
   logic [7:0] loss_count;

   always_ff @(posedge clk_in) begin
      if (!reset_in) begin
         loss_count <= 8'h00;
      end else if (lock_lost && (loss_count != 8'hFF)) begin
         loss_count <= loss_count + 8'h01;
      end
   end

   assign loss_count_out = loss_count;
`else
   assign loss_count_out = 8'h00;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed scenarios plus random lock/request traffic against a
// cycle-count reference model of the staged reset release.
module tb_reset_sequencer;
   localparam int N   = 3;
   localparam int LSC = 16;
   localparam int SD  = 8;
   localparam int MA  = 4;
`ifdef RESET_SEQ_LOSS_COUNT_EN
   localparam int LOSS_EN = 1;
`else
   localparam int LOSS_EN = 0;
`endif

   localparam int P_ASSERT = 0;
   localparam int P_WAIT   = 1;
   localparam int P_STABLE = 2;
   localparam int P_REL    = 3;
   localparam int P_RUN    = 4;

   logic         clk_in = 1'b0;
   logic         reset_in = 1'b0;
   logic         pll_locked_in = 1'b1;
   logic         sw_reset_req = 1'b0;
   logic [N-1:0] reset_out;
   logic         ready_out;
   logic [7:0]   loss_count_out;

   int checks = 0;
   int failures = 0;

   int m_phase, m_assert, m_stable, m_rel, m_loss, m_s1, m_s2;
   int edge_n, t_b0, t_b1, t_rdy, t_all;

   reset_sequencer #(
      .NUM_DOMAINS(N), .LOCK_STABLE_CYCLES(LSC), .STAGE_DELAY(SD), .MIN_ASSERT(MA)
   ) dut (
      .clk_in(clk_in), .reset_in(reset_in), .pll_locked_in(pll_locked_in),
      .sw_reset_req(sw_reset_req), .reset_out(reset_out), .ready_out(ready_out),
      .loss_count_out(loss_count_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference: counts elapsed cycles per phase and derives outputs from them.
   task automatic model_step();
      int ls;
      bit lost;
      if (!reset_in) begin
         m_phase = P_ASSERT; m_assert = 0; m_stable = 0; m_rel = 0;
         m_loss = 0; m_s1 = 0; m_s2 = 0;
      end else begin
         ls   = m_s2;
         m_s2 = m_s1;
         m_s1 = int'(pll_locked_in);
         lost = ((m_phase == P_REL) || (m_phase == P_RUN)) && (ls == 0);
         if (lost && LOSS_EN == 1 && m_loss < 255) m_loss++;
         if (sw_reset_req || lost) begin
            m_phase = P_ASSERT; m_assert = 0;
         end else begin
            case (m_phase)
               P_ASSERT: begin m_assert++; if (m_assert == MA) m_phase = P_WAIT; end
               P_WAIT:   if (ls == 1) begin m_phase = P_STABLE; m_stable = 0; end
               P_STABLE: begin
                  if (ls == 0) m_phase = P_WAIT;
                  else begin
                     m_stable++;
                     if (m_stable == LSC) begin m_phase = P_REL; m_rel = 0; end
                  end
               end
               P_REL:    begin m_rel++; if (m_rel == N * SD) m_phase = P_RUN; end
               default:  ;
            endcase
         end
      end
   endtask

   function automatic logic [N-1:0] exp_rst();
      logic [N-1:0] r;
      r = '1;
      if (m_phase == P_RUN) r = '0;
      else if (m_phase == P_REL)
         for (int i = 0; i < N; i++) if (m_rel >= (i + 1) * SD) r[i] = 1'b0;
      return r;
   endfunction

   task automatic tick();
      @(posedge clk_in);
      model_step();
      edge_n++;
      @(negedge clk_in);
      check("reset_out", 32'(reset_out), 32'(exp_rst()));
      check("ready_out", 32'(ready_out), 32'(m_phase == P_RUN));
      check("loss_count", 32'(loss_count_out), 32'(m_loss));
      if (t_b0 < 0 && !reset_out[0]) t_b0 = edge_n;
      if (t_b1 < 0 && !reset_out[1]) t_b1 = edge_n;
      if (t_rdy < 0 && ready_out) t_rdy = edge_n;
      if (t_all < 0 && reset_out == {N{1'b1}} && !ready_out) t_all = edge_n;
   endtask

   task automatic clear_marks();
      edge_n = 0; t_b0 = -1; t_b1 = -1; t_rdy = -1; t_all = -1;
   endtask

   task automatic do_reset();
      reset_in = 1'b0;
      tick();
      tick();
      reset_in = 1'b1;
      clear_marks();
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      clear_marks();
      // Power-up with lock held high.
      pll_locked_in = 1'b1;
      do_reset();
      check("reset_state", 32'(reset_out), 32'h7);
      ticks(50);
      check("bit0_release_edge", 32'(t_b0), 32'd29);
      check("bit1_release_edge", 32'(t_b1), 32'd37);
      check("ready_edge", 32'(t_rdy), 32'd45);

      // One-cycle lock glitch mid-STABLE restarts the stable count; not a loss event.
      do_reset();
      ticks(9);
      pll_locked_in = 1'b0;
      tick();
      pll_locked_in = 1'b1;
      ticks(4);
      check("glitch_resets_held", 32'(reset_out), 32'h7);
      ticks(50);
      check("glitch_ready_edge", 32'(t_rdy), 32'd53);
      check("glitch_no_loss", 32'(loss_count_out), 32'd0);

      // Software request in RELEASE after bit0 released.
      do_reset();
      ticks(30);
      sw_reset_req = 1'b1;
      tick();
      sw_reset_req = 1'b0;
      check("sw_reassert", 32'(reset_out), 32'h7);
      ticks(4);
      check("sw_hold", 32'({ready_out, reset_out}), 32'h7);
      ticks(45);
      check("sw_ready_edge", 32'(t_rdy), 32'd76);
      check("sw_no_loss", 32'(loss_count_out), 32'd0);

      // Lock drop in RUN: resets reassert three edges after the fall.
      clear_marks();
      pll_locked_in = 1'b0;
      ticks(5);
      check("loss_latency", 32'(t_all), 32'd3);
      check("loss_count_one", 32'(loss_count_out), 32'(LOSS_EN));
      pll_locked_in = 1'b1;
      clear_marks();
      ticks(60);
      check("relock_ready", 32'(ready_out), 32'd1);

      // Reset pulse during RELEASE.
      do_reset();
      ticks(25);
      reset_in = 1'b0;
      tick();
      reset_in = 1'b1;
      check("midrst_outputs", 32'({loss_count_out, ready_out, reset_out}), 32'h7);
      clear_marks();
      ticks(50);
      check("midrst_ready_edge", 32'(t_rdy), 32'd45);

      // Simultaneous lock loss and software request, repeated until saturation.
      for (int k = 0; k < 300; k++) begin
         pll_locked_in = 1'b1;
         ticks(50);
         pll_locked_in = 1'b0;
         ticks(2);
         sw_reset_req = 1'b1;
         tick();
         sw_reset_req = 1'b0;
      end
      check("loss_saturated", 32'(loss_count_out), 32'(LOSS_EN * 255));

      // Random traffic.
      pll_locked_in = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         reset_in = ($urandom_range(0, 299) != 0);
         sw_reset_req = ($urandom_range(0, 149) == 0);
         if (pll_locked_in) pll_locked_in = ($urandom_range(0, 79) != 0);
         else pll_locked_in = ($urandom_range(0, 2) == 0);
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
